// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and id helper for the 4:1 round-robin lane arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ     = 4;
  localparam int ID_W        = 2;
  localparam int BURST_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot = NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_picker
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      offset;

  // Rotating a doubled copy puts the request at rr_ptr into bit 0.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[{1'b0, rr_ptr} +: NUM_REQ];

  always_comb begin
    offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = ID_W'(k);
    end
  end

  assign winner  = rr_ptr + offset;
  assign any_req = |req;

endmodule

// File: rtl/mux4x1_arbiter.sv
// Round-robin 4:1 byte arbiter, BURST beats per grant; MUX_ARB_STATS_EN adds grant_cnt counters.
// Latency 1 cycle in->out; ready drops while out is stalled, one bubble per grant.
module mux4x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [3:0]       valid,
  output logic [3:0]       ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       grant_id
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [63:0]      grant_cnt
`endif
);

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        owner;
  logic [ID_W-1:0]        winner;
  logic [BURST_CNT_W-1:0] beat_cnt;
  logic                   any_req;
  logic                   slot_free;
  logic                   accept;
  logic                   last_beat;
  logic                   release_grant;
  logic [WIDTH-1:0]       owner_dat;

  rr_picker u_picker (
    .req     (valid),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign slot_free = ~out_valid | out_ready;
  assign ready     = (state == BUSY && slot_free && !reset) ? id_onehot(owner) : '0;
  assign accept    = |(valid & ready);
  assign last_beat = (beat_cnt == BURST_CNT_W'(BURST - 1));

  // A stalled slot keeps the grant even if the owner withdraws valid.
  assign release_grant = (accept && last_beat) || (slot_free && !valid[owner]);

  always_comb begin
    case (owner)
      2'd0:    owner_dat = in0;
      2'd1:    owner_dat = in1;
      2'd2:    owner_dat = in2;
      default: owner_dat = in3;
    endcase
  end

  always_ff @(posedge clk4f) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      grant_id  <= '0;
    end else begin
      if (accept) begin
        out       <= owner_dat;
        out_valid <= 1'b1;
        grant_id  <= owner;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            owner    <= winner;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_grant) begin
            rr_ptr   <= owner + 2'd1;
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic [15:0] gcnt [NUM_REQ];

  always_ff @(posedge clk4f) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
    end else if (state == IDLE && any_req) begin
      gcnt[winner] <= gcnt[winner] + 16'd1;
    end
  end

  assign grant_cnt = {gcnt[3], gcnt[2], gcnt[1], gcnt[0]};
`endif

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Directed bench for mux4x1_arbiter: per-requester source queues, cycle model, literal pins.
module tb_mux4x1_arbiter;

  localparam int BURST = 4;

  logic       clk4f = 1'b0;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] grant_id;
`ifdef MUX_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  always #5 clk4f = ~clk4f;

  mux4x1_arbiter #(.WIDTH(8), .BURST(BURST)) dut (
    .clk4f     (clk4f),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .valid     (valid),
    .ready     (ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id)
`ifdef MUX_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$], q1[$], q2[$], q3[$];
  logic [3:0] mask = 4'hF;
  bit         chk_en = 1'b0;

  // Model state: plain integers, beats counted 1..BURST.
  bit         m_busy;
  int         m_ptr, m_owner, m_cnt, m_gid;
  logic [7:0] m_out;
  bit         m_ov;
  int         m_gcnt[4];

  logic [3:0] smp_rdy;
  logic [7:0] smp_out;
  logic       smp_ov;
  logic [1:0] smp_gid;
  logic [9:0] em[$];
  logic [9:0] xq[$];
  logic [9:0] trace;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] in_of(input int i);
    case (i)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  task automatic push(input int i, input logic [7:0] d);
    case (i)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      2:       q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic pop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      2:       void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic drive();
    valid[0] = mask[0] && (q0.size() > 0);
    valid[1] = mask[1] && (q1.size() > 0);
    valid[2] = mask[2] && (q2.size() > 0);
    valid[3] = mask[3] && (q3.size() > 0);
    in0 = (q0.size() > 0) ? q0[0] : 8'h00;
    in1 = (q1.size() > 0) ? q1[0] : 8'h00;
    in2 = (q2.size() > 0) ? q2[0] : 8'h00;
    in3 = (q3.size() > 0) ? q3[0] : 8'h00;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_gid = 0;
    m_out = 8'h00; m_ov = 1'b0;
    for (int i = 0; i < 4; i++) m_gcnt[i] = 0;
  endtask

  task automatic release_model();
    m_ptr  = (m_owner + 1) % 4;
    m_cnt  = 0;
    m_busy = 1'b0;
  endtask

  // One clock: compare at negedge, advance model, then update sources after the edge.
  task automatic tick();
    bit         free;
    bit         found;
    logic [3:0] mrdy;
    logic [3:0] acc;
    @(negedge clk4f);
    free = !m_ov || out_ready;
    mrdy = (m_busy && free && !reset) ? 4'(1 << m_owner) : 4'b0000;
    smp_rdy = ready; smp_out = out; smp_ov = out_valid; smp_gid = grant_id;
    if (chk_en) begin
      chk("ready", 64'(ready), 64'(mrdy));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out", 64'(out), 64'(m_out));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
`ifdef MUX_ARB_STATS_EN
      chk("grant_cnt", grant_cnt, {16'(m_gcnt[3]), 16'(m_gcnt[2]), 16'(m_gcnt[1]), 16'(m_gcnt[0])});
`endif
    end
    if (out_valid === 1'b1 && out_ready) em.push_back({grant_id, out});
    acc = valid & mrdy;
    if (reset) begin
      model_reset();
    end else begin
      if (acc != 0) begin
        m_out = in_of(m_owner); m_ov = 1'b1; m_gid = m_owner;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (!m_busy) begin
        if (valid != 0) begin
          found = 1'b0;
          for (int k = 0; k < 4; k++) begin
            if (!found && valid[(m_ptr + k) % 4]) begin
              m_owner = (m_ptr + k) % 4;
              found = 1'b1;
            end
          end
          m_busy = 1'b1; m_cnt = 0;
          m_gcnt[m_owner] = (m_gcnt[m_owner] + 1) % 65536;
        end
      end else if (acc != 0) begin
        m_cnt++;
        if (m_cnt == BURST) release_model();
      end else if (free && !valid[m_owner]) begin
        release_model();
      end
    end
    for (int i = 0; i < 4; i++) if (acc[i]) pop(i);
    @(posedge clk4f);
    #1;
    drive();
  endtask

  task automatic restart();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    mask = 4'hF; out_ready = 1'b1; reset = 1'b1;
    drive();
    tick();
    reset = 1'b0;
    drive();
    em.delete();
    xq.delete();
  endtask

  task automatic cmp_em(input string name);
    chk({name, "_count"}, 64'(em.size()), 64'(xq.size()));
    for (int i = 0; i < xq.size() && i < em.size(); i++)
      chk(name, 64'(em[i]), 64'(xq[i]));
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1; mask = 4'hF;
    for (int i = 0; i < 4; i++) push(i, 8'(8'h10 * i));
    drive();
    model_reset();
    @(posedge clk4f);
    #1;
    chk_en = 1'b1;

    // Reset held with every requester valid.
    repeat (2) begin
      tick();
      chk("rst_ready", 64'(smp_rdy), 64'h0);
      chk("rst_out", 64'(smp_out), 64'h0);
      chk("rst_out_valid", 64'(smp_ov), 64'h0);
      chk("rst_grant_id", 64'(smp_gid), 64'h0);
    end
    reset = 1'b0;
    drive();
    tick();
    chk("first_bubble", 64'(smp_rdy), 64'h0);
    tick();
    chk("first_grant", 64'(smp_rdy), 64'b0001);

    // Single requester, six beats: burst of four, one gap, then two more.
    restart();
    for (int b = 0; b < 6; b++) push(2, 8'(8'hA0 + b));
    drive();
    trace = '0;
    repeat (10) begin
      tick();
      trace = {trace[8:0], smp_ov};
    end
    chk("s1_ov_trace", 64'(trace), 64'(10'b0011110110));
    for (int b = 0; b < 6; b++) xq.push_back({2'd2, 8'(8'hA0 + b)});
    cmp_em("s1_beats");
`ifdef MUX_ARB_STATS_EN
    chk("s1_grant_cnt2", 64'(grant_cnt[47:32]), 64'd2);
`endif

    // All four continuously valid.
    restart();
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 12; b++) push(i, 8'(8'h10 * i + b));
    drive();
    repeat (22) tick();
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++) xq.push_back({2'(g), 8'(8'h10 * g + b)});
    cmp_em("rr_order");

    // Backpressure on owner 1, valid withdrawn during the stall.
    restart();
    for (int b = 0; b < 6; b++) push(1, 8'(8'h50 + b));
    drive();
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    chk("bp_hold_out", 64'(smp_out), 64'h51);
    chk("bp_hold_ov", 64'(smp_ov), 64'h1);
    chk("bp_hold_ready", 64'(smp_rdy), 64'h0);
    mask = 4'b1101;
    drive();
    repeat (2) begin
      tick();
      chk("bp_stall_out", 64'(smp_out), 64'h51);
      chk("bp_stall_ready", 64'(smp_rdy), 64'h0);
    end
    out_ready = 1'b1; mask = 4'hF;
    drive();
    tick();
    chk("bp_resume", 64'(smp_rdy), 64'b0010);
    repeat (6) tick();
    for (int b = 0; b < 6; b++) xq.push_back({2'd1, 8'(8'h50 + b)});
    cmp_em("bp_beats");

    // Owner 3 leaves after two beats; pointer wraps to 0.
    restart();
    push(3, 8'hC0); push(3, 8'hC1);
    drive();
    tick();
    push(0, 8'hB0); push(2, 8'hD0);
    drive();
    repeat (5) tick();
    chk("er_next_grant", 64'(smp_rdy), 64'b0001);
    repeat (4) tick();
    xq.push_back({2'd3, 8'hC0}); xq.push_back({2'd3, 8'hC1});
    xq.push_back({2'd0, 8'hB0}); xq.push_back({2'd2, 8'hD0});
    cmp_em("er_beats");

    // Reset on beat 2 of a grant to requester 1 (pointer was 3 beforehand).
    restart();
    push(2, 8'h60);
    drive();
    repeat (2) tick();
    for (int b = 0; b < 4; b++) push(1, 8'(8'h70 + b));
    drive();
    repeat (3) tick();
    reset = 1'b1;
    drive();
    tick();
    chk("mr_ready_in_reset", 64'(smp_rdy), 64'h0);
`ifdef MUX_ARB_STATS_EN
    chk("mr_grant_cnt_clear", grant_cnt, 64'h0);
`endif
    reset = 1'b0;
    push(3, 8'h90);
    drive();
    tick();
    chk("mr_ov_cleared", 64'(smp_ov), 64'h0);
    tick();
    chk("mr_ptr_zero_grant", 64'(smp_rdy), 64'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
